rf_write_scheduler: RTL and testbench
=====================================

# rf_write_scheduler

Sequences register-file writes from two writeback requesters, the ALU and the data-memory load path, onto the register file's single write port. It buffers one write per requester, arbitrates round-robin, preserves order for same-register writes, discards writes to register 0, and exports per-register pending-write hazard status to decode. It sits between the execute/memory stages and the register file, and it drives the register file's `RegWrite`, write address and write data inputs.

## Interface
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register address width.
- `NREG`, default 32: number of architectural registers, equal to 2**ADDR_W.

- `clk` in, 1: rising-edge clock.
- `rst_n` in, 1: reset, asynchronous and active-low.
- `alu_valid` in, 1: ALU write request.
- `alu_ready` out, 1: ALU request accepted on this edge when `alu_valid` is high.
- `alu_addr` in, ADDR_W: ALU destination register.
- `alu_data` in, DATA_W: ALU result.
- `mem_valid`, `mem_ready`, `mem_addr`, `mem_data`: same as the ALU set, for the load path.
- `rf_we` out, 1: write enable, connected to register-file `RegWrite`.
- `rf_waddr` out, ADDR_W: write register number.
- `rf_wdata` out, DATA_W: write data.
- `rd_addr1`, `rd_addr2` in, ADDR_W: decode source registers.
- `rd_hazard1`, `rd_hazard2` out, 1: the matching source register has a write not yet committed.
- `busy` out, NREG: per-register pending-write vector; bit 0 is always 0.

## Operation
- Each requester owns one holding slot with fields valid, addr, data and seq.
- Ready rule: `x_ready` = slot empty OR slot issuing this cycle.
- `x_ready` is 0 while `rst_n` is low.
- Accept: `x_valid & x_ready` at an edge loads the slot.
- If `x_addr` is 0, the request is accepted but not loaded. It is dropped silently and sets no busy bit.
- Issue, evaluated once per cycle:
  - If only one slot is valid, it issues.
  - If both slots are valid with different addresses, round-robin applies. The `last_grant` flop holds the last winner, and the other requester wins. Reset value of `last_grant` is MEM, so the ALU wins the first tie.
  - If both slots are valid with equal addresses, the older slot issues regardless of `last_grant`. The older slot is the one with the smaller seq, compared by a 1-bit age flag. If both were accepted on the same edge, the ALU is older.
  - `last_grant` updates only on a round-robin decision.
- An issuing slot clears at the edge, unless it is refilled by a simultaneous accept.
- `rf_we`, `rf_waddr` and `rf_wdata` are registered: they load the issued slot's content, or `rf_we` goes to 0 when nothing issues.
- Hazard: `busy[r]` = (alu slot valid & addr==r) | (mem slot valid & addr==r) | (`rf_we` & `rf_waddr`==r), for r != 0.
- `rd_hazardN` = `busy[rd_addrN]`. It is combinational.

## Timing
- Reset values:
  - Both slots empty.
  - `rf_we` = 0; `rf_waddr` = 0; `rf_wdata` = 0.
  - `last_grant` = MEM; age flag = 0.
  - `busy` = 0; hazards = 0.
  - Ready outputs = 0 during reset and 1 in the first cycle after release.
- Latency:
  - Accept at edge N.
  - `rf_we` high in cycle N+1..N+2 if uncontested.
  - The register file commits at edge N+2.
  - Busy is set from just after N until edge N+2.
- Throughput: one write per cycle total. A sustained single requester gets full rate through the skid rule.
- A losing requester stalls at most one cycle per conflict, because round-robin guarantees no starvation.
- Reset asserted mid-operation: slots, pending `rf_we` and busy bits clear immediately and asynchronously. In-flight writes are lost and must not commit.
- Simultaneous accept and issue on the same slot: the new entry is loaded and the old entry goes to the `rf_*` registers in the same edge.

## Structure
- Package `rf_sched_pkg` holds:
  - `DATA_W`, `ADDR_W` and `NREG` defaults.
  - The `ZERO_REG` constant.
  - The requester-id enum: `REQ_ALU`, `REQ_MEM`.
  - A slot struct typedef {valid, addr, data}.
- Sub-module `rf_hold_slot`: one-entry buffer with valid/ready, a zero-address drop, and a `load`/`issue` interface. It is instantiated twice.
- Arbitration, the age flag, the output registers and busy/hazard logic live in the top level.

## Test plan
- Single ALU write r5=0x1234 accepted at edge 1:
  - `rf_we`=1, `rf_waddr`=5 and `rf_wdata`=0x1234 in cycle 2.
  - `busy[5]` is high cycles 1-2 and low after edge 3.
- ALU r3=0xA and MEM r7=0xB accepted on the same edge:
  - ALU issues first, then MEM next cycle.
  - A second concurrent pair then sees MEM first.
- Same-edge ALU r9=1 and MEM r9=2:
  - Commit order is ALU then MEM, with final value 2 and `rd_hazard1` high for `rd_addr1`=9 throughout.
- Write to r0 with data 0xFFFF:
  - Accepted with ready high.
  - `rf_we` never asserts and `busy` stays 0.
- Back-to-back ALU valid for 8 cycles, MEM idle:
  - `alu_ready` stays 1 and 8 consecutive `rf_we` pulses occur.
- `rst_n` pulled low while both slots are full and `rf_we`=1:
  - All outputs are 0 immediately, and no write occurs after release.

Source files
------------

// File: rtl/rf_sched_pkg.sv
// rtl/rf_sched_pkg.sv - shared constants and types for the register-file write scheduler
package rf_sched_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NREG   = 32;
  localparam int ZERO_REG   = 0;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } slot_t;
endpackage

// File: rtl/rf_hold_slot.sv
// rtl/rf_hold_slot.sv - one-entry write holding slot with skid-through ready and r0 drop
module rf_hold_slot
  import rf_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_issue,
  output logic              o_ready,
  output logic              o_load,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Ready while issuing lets a steady requester refill every cycle.
  assign o_ready = rst_n & (~r_valid | i_issue);
  assign o_load  = i_valid & o_ready & (i_addr != ADDR_W'(ZERO_REG));
  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (o_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_issue) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/rf_write_scheduler.sv
// rtl/rf_write_scheduler.sv - arbitrates ALU and load writebacks onto the single RF write port
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NREG   = DEF_NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rd_hazard1,
  output logic              rd_hazard2,
  output logic [NREG-1:0]   busy
);
  logic              w_alu_v, w_mem_v, w_alu_load, w_mem_load;
  logic [ADDR_W-1:0] w_alu_a, w_mem_a;
  logic [DATA_W-1:0] w_alu_d, w_mem_d;
  logic              w_alu_issue, w_mem_issue, w_rr;
  logic              r_alu_older;
  req_id_e           r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  rf_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
    .clk(clk), .rst_n(rst_n), .i_valid(alu_valid), .i_addr(alu_addr), .i_data(alu_data),
    .i_issue(w_alu_issue), .o_ready(alu_ready), .o_load(w_alu_load),
    .o_valid(w_alu_v), .o_addr(w_alu_a), .o_data(w_alu_d)
  );

  rf_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
    .clk(clk), .rst_n(rst_n), .i_valid(mem_valid), .i_addr(mem_addr), .i_data(mem_data),
    .i_issue(w_mem_issue), .o_ready(mem_ready), .o_load(w_mem_load),
    .o_valid(w_mem_v), .o_addr(w_mem_a), .o_data(w_mem_d)
  );

  // Same-register writes bypass round-robin so the older one commits first.
  always_comb begin
    w_alu_issue = 1'b0;
    w_mem_issue = 1'b0;
    w_rr        = 1'b0;
    if (w_alu_v && !w_mem_v) begin
      w_alu_issue = 1'b1;
    end else if (w_mem_v && !w_alu_v) begin
      w_mem_issue = 1'b1;
    end else if (w_alu_v && w_mem_v) begin
      if (w_alu_a == w_mem_a) begin
        w_alu_issue = r_alu_older;
        w_mem_issue = ~r_alu_older;
      end else begin
        w_rr        = 1'b1;
        w_alu_issue = (r_last_grant == REQ_MEM);
        w_mem_issue = (r_last_grant == REQ_ALU);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= REQ_MEM;
      r_alu_older  <= 1'b0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      if (w_rr) r_last_grant <= w_alu_issue ? REQ_ALU : REQ_MEM;
      // A fresh load is younger than whatever stays in the other slot.
      if (w_alu_load && w_mem_load) r_alu_older <= 1'b1;
      else if (w_alu_load)          r_alu_older <= 1'b0;
      else if (w_mem_load)          r_alu_older <= 1'b1;
      if (w_alu_issue) begin
        r_we    <= 1'b1;
        r_waddr <= w_alu_a;
        r_wdata <= w_alu_d;
      end else if (w_mem_issue) begin
        r_we    <= 1'b1;
        r_waddr <= w_mem_a;
        r_wdata <= w_mem_d;
      end else begin
        r_we    <= 1'b0;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  always_comb begin
    busy = '0;
    for (int r = 1; r < NREG; r++) begin
      busy[r] = (w_alu_v && (w_alu_a == ADDR_W'(r))) ||
                (w_mem_v && (w_mem_a == ADDR_W'(r))) ||
                (r_we    && (r_waddr == ADDR_W'(r)));
    end
  end

  assign rd_hazard1 = busy[rd_addr1];
  assign rd_hazard2 = busy[rd_addr2];
endmodule

// File: tb/tb_rf_write_scheduler.sv
// tb/tb_rf_write_scheduler.sv - randomized and directed bench with a sequence-number reference model
module tb_rf_write_scheduler;
  import rf_sched_pkg::*;
  localparam int DW = DEF_DATA_W;
  localparam int AW = DEF_ADDR_W;
  localparam int NR = DEF_NREG;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, mem_valid, alu_ready, mem_ready;
  logic [AW-1:0] alu_addr, mem_addr, rf_waddr, rd_addr1, rd_addr2;
  logic [DW-1:0] alu_data, mem_data, rf_wdata;
  logic          rf_we, rd_hazard1, rd_hazard2;
  logic [NR-1:0] busy;

  int n_vec = 0;
  int n_bad = 0;

  slot_t         m_s[2];
  int            m_seq[2];
  int            seq_cnt;
  logic          m_lg;
  logic          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] exp_rf[NR];
  logic [DW-1:0] bench_rf[NR];

  rf_write_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_hazard1(rd_hazard1), .rd_hazard2(rd_hazard2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // -1 none, 0 ALU, 1 MEM; age is an unbounded sequence number here.
  function automatic int m_issue();
    if (m_s[0].valid && m_s[1].valid) begin
      if (m_s[0].addr == m_s[1].addr) return (m_seq[0] < m_seq[1]) ? 0 : 1;
      return m_lg ? 0 : 1;
    end
    if (m_s[0].valid) return 0;
    if (m_s[1].valid) return 1;
    return -1;
  endfunction

  function automatic logic m_ready(input int i);
    return rst_n && (!m_s[i].valid || m_issue() == i);
  endfunction

  function automatic logic [NR-1:0] m_busy();
    logic [NR-1:0] b;
    b = '0;
    for (int r = 1; r < NR; r++)
      b[r] = (m_s[0].valid && m_s[0].addr == AW'(r)) || (m_s[1].valid && m_s[1].addr == AW'(r)) ||
             (m_we && m_wa == AW'(r));
    return b;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 2; i++) begin
      m_s[i] = '{valid: 1'b0, addr: '0, data: '0};
      m_seq[i] = 0;
    end
    m_lg = 1'b1;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic m_step();
    int   is;
    logic r0, r1;
    is = m_issue();
    r0 = !m_s[0].valid || is == 0;
    r1 = !m_s[1].valid || is == 1;
    if (m_s[0].valid && m_s[1].valid && m_s[0].addr != m_s[1].addr) m_lg = (is == 1);
    if (is >= 0) begin
      m_we = 1'b1;
      m_wa = m_s[is].addr;
      m_wd = m_s[is].data;
      m_s[is].valid = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (alu_valid && r0 && alu_addr != 0) begin
      m_s[0] = '{valid: 1'b1, addr: alu_addr, data: alu_data};
      m_seq[0] = seq_cnt;
      seq_cnt++;
      exp_rf[alu_addr] = alu_data;
    end
    if (mem_valid && r1 && mem_addr != 0) begin
      m_s[1] = '{valid: 1'b1, addr: mem_addr, data: mem_data};
      m_seq[1] = seq_cnt;
      seq_cnt++;
      exp_rf[mem_addr] = mem_data;
    end
  endtask

  initial begin
    seq_cnt = 0;
    for (int r = 0; r < NR; r++) begin
      exp_rf[r]   = '0;
      bench_rf[r] = '0;
    end
    m_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_clear();
        for (int r = 0; r < NR; r++) exp_rf[r] = bench_rf[r];
      end else begin
        m_step();
      end
    end
  end

  initial forever begin
    logic [NR-1:0] eb;
    @(negedge clk);
    eb = m_busy();
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_wa);
    chk("rf_wdata", rf_wdata, m_wd);
    chk("alu_ready", alu_ready, m_ready(0));
    chk("mem_ready", mem_ready, m_ready(1));
    chk("busy", busy, eb);
    chk("rd_hazard1", rd_hazard1, eb[rd_addr1]);
    chk("rd_hazard2", rd_hazard2, eb[rd_addr2]);
  end

  // Register file stand-in fed only by the DUT's write port.
  initial forever begin
    logic          cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    @(negedge clk);
    cw = rf_we;
    ca = rf_waddr;
    cd = rf_wdata;
    @(posedge clk);
    if (rst_n && cw) bench_rf[ca] = cd;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
  endtask

  initial begin
    int pulses, run, maxrun;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    rd_addr1 = '0;
    rd_addr2 = '0;
    #1 rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset_alu", alu_ready, 1);
    chk("ready_after_reset_mem", mem_ready, 1);
    chk("busy_reset", busy, 0);

    // single ALU write r5
    drive(1, 5, 32'h1234, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t1_busy5_c1", busy[5], 1);
    chk("t1_we_c1", rf_we, 0);
    cyc();
    @(negedge clk);
    chk("t1_we_c2", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    chk("t1_busy5_c2", busy[5], 1);
    cyc();
    @(negedge clk);
    chk("t1_we_c3", rf_we, 0);
    chk("t1_busy5_c3", busy[5], 0);

    // concurrent pairs alternate via round-robin
    drive(1, 3, 32'hA, 1, 7, 32'hB);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    @(negedge clk);
    chk("rr1_first_addr", rf_waddr, 3);
    chk("rr1_first_data", rf_wdata, 32'hA);
    cyc();
    @(negedge clk);
    chk("rr1_second_addr", rf_waddr, 7);
    chk("rr1_second_data", rf_wdata, 32'hB);
    drive(1, 4, 32'hC, 1, 8, 32'hD);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    @(negedge clk);
    chk("rr2_first_addr", rf_waddr, 8);
    cyc();
    @(negedge clk);
    chk("rr2_second_addr", rf_waddr, 4);

    // same-register pair keeps ALU-then-MEM order
    rd_addr1 = 9;
    drive(1, 9, 1, 1, 9, 2);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("same_hz_c1", rd_hazard1, 1);
    cyc();
    @(negedge clk);
    chk("same_first_addr", rf_waddr, 9);
    chk("same_first_data", rf_wdata, 1);
    chk("same_hz_c2", rd_hazard1, 1);
    cyc();
    @(negedge clk);
    chk("same_second_data", rf_wdata, 2);
    chk("same_hz_c3", rd_hazard1, 1);
    cyc();
    @(negedge clk);
    chk("same_final_r9", bench_rf[9], 2);
    chk("same_hz_done", rd_hazard1, 0);

    // write to r0 is swallowed
    drive(1, 0, 32'hFFFF, 0, 0, 0);
    @(negedge clk);
    chk("r0_ready", alu_ready, 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r0_no_we", rf_we, 0);
      chk("r0_no_busy", busy, 0);
      cyc();
    end

    // sustained single requester at full rate
    pulses = 0; run = 0; maxrun = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, AW'(i + 1), DW'(i), 0, 0, 0);
      @(negedge clk);
      chk("b2b_ready", alu_ready, 1);
      if (rf_we) begin pulses++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rf_we) begin pulses++; run++; end else run = 0;
      if (run > maxrun) maxrun = run;
      cyc();
    end
    chk("b2b_pulses", pulses, 8);
    chk("b2b_consecutive", maxrun, 8);

    // reset with both slots full and a write in flight
    drive(1, 10, 32'h55, 1, 11, 32'h66);
    cyc();
    alu_data = 32'h77;
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_pre_we", rf_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_mem_ready", mem_ready, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_we", rf_we, 0);
      cyc();
    end
    chk("rst_r10_lost", bench_rf[10], 0);
    chk("rst_r11_lost", bench_rf[11], 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), DW'($urandom),
            $urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), DW'($urandom));
      rd_addr1 = AW'($urandom_range(0, 7));
      rd_addr2 = AW'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
      end else begin
        cyc();
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) cyc();
    for (int r = 0; r < NR; r++) chk($sformatf("final_r%0d", r), bench_rf[r], exp_rf[r]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
